// File: rtl/interrupt_ack_sequencer.sv
// INTA acknowledge / poll sequencer for an 8259A-style interrupt controller.
// Every output is registered; the state machine drives ISR/IRR strobes and byte selection.
module interrupt_ack_sequencer #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               write_icw1,
   input  logic [NUM_IRQ-1:0] interrupt,
   input  logic               inta_edge,
   input  logic               poll_command,
   input  logic               poll_read,
   input  logic               mode_8086,
   input  logic               auto_eoi,
   output logic               interrupt_to_cpu,
   output logic               freeze,
   output logic [2:0]         control_state,
   output logic               latch_in_service,
   output logic [NUM_IRQ-1:0] acknowledge_interrupt,
   output logic [NUM_IRQ-1:0] clear_interrupt_request,
   output logic [NUM_IRQ-1:0] interrupt_when_ack1,
   output logic               spurious,
   output logic               end_of_ack,
   output logic               end_of_poll,
   output logic [NUM_IRQ-1:0] auto_eoi_clear,
   output logic [1:0]         byte_select
);

   localparam logic [2:0] READY = 3'd0;
   localparam logic [2:0] ACK1  = 3'd1;
   localparam logic [2:0] ACK2  = 3'd2;
   localparam logic [2:0] ACK3  = 3'd3;
   localparam logic [2:0] POLL  = 3'd4;

   logic [2:0]         r_state;
   logic               r_mode;
   logic               r_int;
   logic               r_freeze;
   logic               r_latch;
   logic [NUM_IRQ-1:0] r_ack;
   logic [NUM_IRQ-1:0] r_clr;
   logic [NUM_IRQ-1:0] r_snap;
   logic               r_spur;
   logic               r_eoa;
   logic               r_eop;
   logic [NUM_IRQ-1:0] r_aeoi;
   logic [1:0]         r_bsel;

   logic [2:0] w_next;
   logic [1:0] w_bsel;
   logic       w_mode;
   logic       w_irq;
   logic       w_start;
   logic       w_end_ack;
   logic       w_poll_rd;

   assign w_irq     = |interrupt;
   assign w_start   = !write_icw1 && inta_edge && (r_state == READY);
   assign w_end_ack = !write_icw1 && inta_edge &&
                      (((r_state == ACK1) && r_mode) || (r_state == ACK2));
   assign w_poll_rd = !write_icw1 && poll_read && (r_state == POLL);

   // Mode is live outside a sequence and frozen inside one.
   assign w_mode = ((r_state == READY) || (w_next == READY)) ? mode_8086 : r_mode;

   always_comb begin
      w_next = r_state;
      case (r_state)
         READY: begin
            if (inta_edge) w_next = ACK1;
            else if (poll_command) w_next = POLL;
         end
         ACK1:  if (inta_edge) w_next = r_mode ? READY : ACK2;
         ACK2:  if (inta_edge) w_next = ACK3;
         ACK3:  w_next = READY;
         POLL:  if (poll_read) w_next = READY;
         default: w_next = READY;
      endcase
      if (write_icw1) w_next = READY;
   end

   always_comb begin
      w_bsel = 2'd0;
      if (!write_icw1) begin
         case (w_next)
            READY:   w_bsel = w_mode ? 2'd0 : 2'd1;
            ACK1:    w_bsel = 2'd2;
            ACK2:    w_bsel = w_mode ? 2'd0 : 2'd3;
            default: w_bsel = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= READY;
         r_mode   <= 1'b0;
         r_int    <= 1'b0;
         r_freeze <= 1'b0;
         r_latch  <= 1'b0;
         r_ack    <= '0;
         r_clr    <= '0;
         r_snap   <= '0;
         r_spur   <= 1'b0;
         r_eoa    <= 1'b0;
         r_eop    <= 1'b0;
         r_aeoi   <= '0;
         r_bsel   <= 2'd0;
      end else begin
         r_state  <= w_next;
         r_freeze <= (w_next != READY);
         r_bsel   <= w_bsel;
         r_latch  <= 1'b0;
         r_clr    <= '0;
         r_eoa    <= 1'b0;
         r_eop    <= 1'b0;
         r_aeoi   <= '0;
         if (write_icw1) begin
            r_clr  <= '1;
            r_int  <= 1'b0;
            r_ack  <= '0;
            r_snap <= '0;
            r_spur <= 1'b0;
            r_mode <= 1'b0;
         end else begin
            if (w_end_ack || w_poll_rd) r_int <= 1'b0;
            else if ((r_state == READY) && w_irq) r_int <= 1'b1;
            if (w_start) begin
               r_mode  <= mode_8086;
               r_snap  <= interrupt;
               r_ack   <= interrupt;
               r_clr   <= interrupt;
               r_latch <= w_irq;
               r_spur  <= !w_irq;
            end else if (w_poll_rd) begin
               r_ack   <= interrupt;
               r_clr   <= interrupt;
               r_latch <= w_irq;
               r_eop   <= 1'b1;
            end else if (r_eoa || r_eop) begin
               r_ack <= '0;
            end
            if (w_end_ack) begin
               r_eoa  <= 1'b1;
               r_spur <= 1'b0;
               if (auto_eoi && !r_spur) r_aeoi <= r_ack;
            end
         end
      end
   end

   assign interrupt_to_cpu        = r_int;
   assign freeze                  = r_freeze;
   assign control_state           = r_state;
   assign latch_in_service        = r_latch;
   assign acknowledge_interrupt   = r_ack;
   assign clear_interrupt_request = r_clr;
   assign interrupt_when_ack1     = r_snap;
   assign spurious                = r_spur;
   assign end_of_ack              = r_eoa;
   assign end_of_poll             = r_eop;
   assign auto_eoi_clear          = r_aeoi;
   assign byte_select             = r_bsel;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Randomized transaction-level bench for interrupt_ack_sequencer.
// Expected outputs come from a per-transaction model of the acknowledge rules.
module tb_interrupt_ack_sequencer;

   typedef struct packed {
      logic       int_o;
      logic       frz;
      logic [2:0] st;
      logic       lat;
      logic [7:0] ack;
      logic [7:0] clr;
      logic [7:0] snap;
      logic       spur;
      logic       eoa;
      logic       eop;
      logic [7:0] aeoi;
      logic [1:0] bsel;
   } out_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       write_icw1 = 1'b0;
   logic [7:0] interrupt = 8'h00;
   logic       inta_edge = 1'b0;
   logic       poll_command = 1'b0;
   logic       poll_read = 1'b0;
   logic       mode_8086 = 1'b0;
   logic       auto_eoi = 1'b0;

   logic       o_int, o_frz, o_lat, o_spur, o_eoa, o_eop;
   logic [2:0] o_st;
   logic [7:0] o_ack, o_clr, o_snap, o_aeoi;
   logic [1:0] o_bsel;

   logic [15:0] in16;
   logic        p_int, p_frz, p_lat, p_spur, p_eoa, p_eop;
   logic [2:0]  p_st;
   logic [15:0] p_ack, p_clr, p_snap, p_aeoi;
   logic [1:0]  p_bsel;

   out_t obs;
   out_t e;
   int   n_tests = 0;
   int   n_fail = 0;
   logic       m_int = 1'b0;
   logic [7:0] m_snap = 8'h00;
   logic       m_mode = 1'b0;

   assign in16 = {interrupt, 8'h00};
   assign obs = {o_int, o_frz, o_st, o_lat, o_ack, o_clr, o_snap,
                 o_spur, o_eoa, o_eop, o_aeoi, o_bsel};

   interrupt_ack_sequencer #(.NUM_IRQ(8)) dut (
      .clock(clock), .reset_n(reset_n), .write_icw1(write_icw1),
      .interrupt(interrupt), .inta_edge(inta_edge),
      .poll_command(poll_command), .poll_read(poll_read),
      .mode_8086(mode_8086), .auto_eoi(auto_eoi),
      .interrupt_to_cpu(o_int), .freeze(o_frz), .control_state(o_st),
      .latch_in_service(o_lat), .acknowledge_interrupt(o_ack),
      .clear_interrupt_request(o_clr), .interrupt_when_ack1(o_snap),
      .spurious(o_spur), .end_of_ack(o_eoa), .end_of_poll(o_eop),
      .auto_eoi_clear(o_aeoi), .byte_select(o_bsel)
   );

   interrupt_ack_sequencer #(.NUM_IRQ(16)) dut16 (
      .clock(clock), .reset_n(reset_n), .write_icw1(write_icw1),
      .interrupt(in16), .inta_edge(inta_edge),
      .poll_command(poll_command), .poll_read(poll_read),
      .mode_8086(mode_8086), .auto_eoi(auto_eoi),
      .interrupt_to_cpu(p_int), .freeze(p_frz), .control_state(p_st),
      .latch_in_service(p_lat), .acknowledge_interrupt(p_ack),
      .clear_interrupt_request(p_clr), .interrupt_when_ack1(p_snap),
      .spurious(p_spur), .end_of_ack(p_eoa), .end_of_poll(p_eop),
      .auto_eoi_clear(p_aeoi), .byte_select(p_bsel)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Quiescent READY outputs implied by the model state.
   function automatic out_t idle_exp();
      out_t v;
      v = '0;
      v.int_o = m_int;
      v.snap = m_snap;
      v.bsel = m_mode ? 2'd0 : 2'd1;
      return v;
   endfunction

   task automatic test_reset();
      repeat (2) tick();
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h want 0", obs);
      end
      reset_n = 1'b1;
      tick();
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL reset_release: got %h want %h", obs, e);
      end
   endtask

   task automatic test_ack(input logic [7:0] rq, input logic [7:0] ak,
                           input logic md, input logic ae);
      int g;
      mode_8086 = md;
      auto_eoi = ae;
      m_mode = md;
      interrupt = rq;
      tick();
      m_int = m_int | (rq != 8'h00);
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL ack_request: got %h want %h", obs, e);
      end
      interrupt = ak;
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      m_int = m_int | (ak != 8'h00);
      m_snap = ak;
      e = '0;
      e.int_o = m_int;
      e.frz = 1'b1;
      e.st = 3'd1;
      e.lat = (ak != 8'h00);
      e.ack = ak;
      e.clr = ak;
      e.snap = ak;
      e.spur = (ak == 8'h00);
      e.bsel = 2'd2;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL ack_first: got %h want %h", obs, e);
      end
      e.lat = 1'b0;
      e.clr = 8'h00;
      g = $urandom_range(0, 2);
      repeat (g) begin
         tick();
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ack_hold1: got %h want %h", obs, e);
         end
      end
      if (!md) begin
         inta_edge = 1'b1;
         tick();
         inta_edge = 1'b0;
         e.st = 3'd2;
         e.bsel = 2'd3;
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ack_second: got %h want %h", obs, e);
         end
         g = $urandom_range(0, 2);
         repeat (g) begin
            tick();
            n_tests++;
            if (obs !== e) begin
               n_fail++;
               $display("FAIL ack_hold2: got %h want %h", obs, e);
            end
         end
      end
      interrupt = 8'h00;
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      m_int = 1'b0;
      e.int_o = 1'b0;
      e.spur = 1'b0;
      e.eoa = 1'b1;
      e.aeoi = (ae && ak != 8'h00) ? ak : 8'h00;
      e.st = md ? 3'd0 : 3'd3;
      e.frz = !md;
      e.bsel = 2'd0;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL ack_end: got %h want %h", obs, e);
      end
      tick();
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL ack_after: got %h want %h", obs, e);
      end
   endtask

   task automatic test_poll(input logic [7:0] irq);
      interrupt = 8'h00;
      poll_read = 1'b1;
      tick();
      poll_read = 1'b0;
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL poll_read_idle: got %h want %h", obs, e);
      end
      poll_command = 1'b1;
      tick();
      poll_command = 1'b0;
      e.st = 3'd4;
      e.frz = 1'b1;
      e.bsel = 2'd0;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL poll_enter: got %h want %h", obs, e);
      end
      interrupt = irq;
      inta_edge = 1'b1;
      poll_command = 1'b1;
      tick();
      inta_edge = 1'b0;
      poll_command = 1'b0;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL poll_ignore: got %h want %h", obs, e);
      end
      poll_read = 1'b1;
      tick();
      poll_read = 1'b0;
      interrupt = 8'h00;
      e = idle_exp();
      e.lat = (irq != 8'h00);
      e.clr = irq;
      e.ack = irq;
      e.eop = 1'b1;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL poll_read: got %h want %h", obs, e);
      end
      tick();
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL poll_after: got %h want %h", obs, e);
      end
   endtask

   task automatic test_icw1();
      mode_8086 = 1'b0;
      m_mode = 1'b0;
      auto_eoi = 1'b0;
      interrupt = 8'h20;
      tick();
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      poll_command = 1'b1;
      tick();
      poll_command = 1'b0;
      e = '0;
      e.int_o = 1'b1;
      e.frz = 1'b1;
      e.st = 3'd1;
      e.ack = 8'h20;
      e.snap = 8'h20;
      e.bsel = 2'd2;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL icw1_pollcmd_in_ack: got %h want %h", obs, e);
      end
      inta_edge = 1'b1;
      tick();
      interrupt = 8'h00;
      write_icw1 = 1'b1;
      tick();
      write_icw1 = 1'b0;
      inta_edge = 1'b0;
      m_int = 1'b0;
      m_snap = 8'h00;
      e = '0;
      e.clr = 8'hFF;
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL icw1_clear: got %h want %h", obs, e);
      end
      tick();
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL icw1_after: got %h want %h", obs, e);
      end
   endtask

   task automatic test_reset_mid();
      mode_8086 = 1'b1;
      interrupt = 8'h08;
      tick();
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got %h want 0", obs);
      end
      tick();
      interrupt = 8'h00;
      mode_8086 = 1'b0;
      m_mode = 1'b0;
      m_int = 1'b0;
      m_snap = 8'h00;
      reset_n = 1'b1;
      tick();
      e = idle_exp();
      n_tests++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL reset_recover: got %h want %h", obs, e);
      end
   endtask

   task automatic test_irq16();
      mode_8086 = 1'b1;
      m_mode = 1'b1;
      auto_eoi = 1'b1;
      interrupt = 8'h01;
      tick();
      n_tests++;
      if ({p_int, p_st, p_bsel} !== {1'b1, 3'd0, 2'd0}) begin
         n_fail++;
         $display("FAIL w16_int: got %b want 1_000_00", {p_int, p_st, p_bsel});
      end
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      n_tests++;
      if ({p_st, p_lat, p_clr, p_ack, p_snap, p_bsel} !==
          {3'd1, 1'b1, 16'h0100, 16'h0100, 16'h0100, 2'd2}) begin
         n_fail++;
         $display("FAIL w16_ack1: st=%0d lat=%b clr=%h ack=%h snap=%h bs=%0d",
                  p_st, p_lat, p_clr, p_ack, p_snap, p_bsel);
      end
      interrupt = 8'h00;
      inta_edge = 1'b1;
      tick();
      inta_edge = 1'b0;
      n_tests++;
      if ({p_st, p_eoa, p_int, p_ack, p_aeoi} !==
          {3'd0, 1'b1, 1'b0, 16'h0100, 16'h0100}) begin
         n_fail++;
         $display("FAIL w16_end: st=%0d eoa=%b int=%b ack=%h aeoi=%h",
                  p_st, p_eoa, p_int, p_ack, p_aeoi);
      end
      tick();
      m_int = 1'b0;
      m_snap = 8'h01;
      n_tests++;
      if ({p_ack, p_aeoi, p_eoa} !== {16'h0000, 16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL w16_after: ack=%h aeoi=%h eoa=%b", p_ack, p_aeoi, p_eoa);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rq;
      logic [7:0] ak;
      int b;
      int kind;
      for (int i = 0; i < 30; i++) begin
         b = $urandom_range(0, 8);
         rq = (b == 8) ? 8'h00 : 8'h01 << b;
         kind = $urandom_range(0, 3);
         ak = (kind == 1) ? 8'h00 : rq;
         if (kind == 3) test_poll(rq);
         else test_ack(rq, ak, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_ack(8'h04, 8'h04, 1'b1, 1'b0);
      test_ack(8'h80, 8'h80, 1'b0, 1'b0);
      test_ack(8'h10, 8'h10, 1'b1, 1'b1);
      test_ack(8'h40, 8'h00, 1'b1, 1'b1);
      test_ack(8'h02, 8'h00, 1'b0, 1'b0);
      test_poll(8'h02);
      test_poll(8'h00);
      test_icw1();
      test_reset_mid();
      test_irq16();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
